alu_arbiter: RTL and testbench

//  Shares one ALU instance (IW in, registered result out) between NUM_REQ requesters.
//  - Round-robin grant; one operation in flight at a time.
//  - Drives the ALU's IW; waits an opcode-dependent latency; captures the ALU result.
//  - Returns the result with the requester id over a valid/ready response channel.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered-output ALU among NUM_REQ requesters.
// Optional performance counters (perf_ops, perf_stall) are enabled by defining ALU_ARB_PERF_EN.

package definitions;
    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        AND = 3'd3,
        OR  = 3'd4,
        XOR = 3'd5
    } opcode_t;

    typedef struct packed {
        opcode_t     opc;
        logic [31:0] a;
        logic [31:0] b;
    } instruction_t;
endpackage

module alu_arbiter
    import definitions::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  instruction_t [NUM_REQ-1:0]   req_iw,
    output instruction_t                 alu_iw,
    input  logic [31:0]                  alu_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [31:0]                  rsp_result,
    output logic                         busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]                  perf_ops,
    output logic [31:0]                  perf_stall
`endif
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    state_t          nextState;
    logic [IDW-1:0]  rrPtr;
    logic [IDW-1:0]  grantIdx;
    logic            grantFound;
    logic            transfer;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] startCnt;
    int              idx;

    // Search upward from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        idx        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rrPtr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grantFound && req_valid[IDW'(idx)]) begin
                grantFound = 1'b1;
                grantIdx   = IDW'(idx);
            end
        end
    end

    assign startCnt = (req_iw[grantIdx].opc == MUL) ? CNTW'(MUL_LATENCY) : CNTW'(1);
    assign transfer = |(req_valid & req_ready);
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grantFound) begin
                    req_ready[grantIdx] = 1'b1;
                    nextState           = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // The ALU result is sampled only once the opcode's latency has fully elapsed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_iw     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            cnt        <= '0;
            rrPtr      <= IDW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        alu_iw <= req_iw[grantIdx];
                        rsp_id <= grantIdx;
                        rrPtr  <= grantIdx;
                        cnt    <= startCnt;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_valid  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (perf_ops != 32'hFFFF_FFFF)) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (rsp_valid && !rsp_ready && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level reference model.

module tb_alu_arbiter;
    import definitions::*;

    localparam int NUM_REQ     = 4;
    localparam int MUL_LATENCY = 3;

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ-1:0]         req_ready;
    instruction_t [NUM_REQ-1:0] req_iw = '0;
    instruction_t               alu_iw;
    logic [31:0]                alu_result = '0;
    logic                       rsp_valid;
    logic                       rsp_ready = 1'b0;
    logic [1:0]                 rsp_id;
    logic [31:0]                rsp_result;
    logic                       busy;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]                perf_ops;
    logic [31:0]                perf_stall;
`endif

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    alu_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MUL_LATENCY(MUL_LATENCY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_iw    (req_iw),
        .alu_iw    (alu_iw),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .busy      (busy)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    function automatic logic [31:0] refResult(input instruction_t iw);
        case (iw.opc)
            ADD:     return iw.a + iw.b;
            SUB:     return iw.a - iw.b;
            MUL:     return iw.a * iw.b;
            AND:     return iw.a & iw.b;
            OR:      return iw.a | iw.b;
            XOR:     return iw.a ^ iw.b;
            default: return 32'd0;
        endcase
    endfunction

    // ALU stand-in: single-edge result for most ops, product appears only after three edges.
    logic [31:0] mulP0 = '0;
    logic [31:0] mulP1 = '0;
    always @(posedge clock) begin
        mulP0      <= alu_iw.a * alu_iw.b;
        mulP1      <= mulP0;
        alu_result <= (alu_iw.opc == MUL) ? mulP1 : refResult(alu_iw);
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out (cycle %0d)", name, cycle);
    endtask

    // Transaction-level reference: who should win next, and when/what the answer must be.
    typedef struct {
        int idx;
        int cyc;
    } grant_t;

    grant_t                grantLog[$];
    bit                    modelBusy = 1'b0;
    int                    lastGrant = NUM_REQ - 1;
    int                    expId;
    int                    expDue;
    int                    monGrant;
    logic [31:0]           expResult;
    instruction_t          expIw;
    logic [NUM_REQ-1:0]    monReady;
    logic [31:0]           modelOps   = '0;
    logic [31:0]           modelStall = '0;

    always @(negedge clock) begin
        if (reset) begin
            modelBusy  = 1'b0;
            lastGrant  = NUM_REQ - 1;
            modelOps   = '0;
            modelStall = '0;
            checkOutput("resetRspValid", rsp_valid, 0);
            checkOutput("resetBusy", busy, 0);
            checkOutput("resetReqReady", req_ready, 0);
            checkOutput("resetAluIw", alu_iw, 0);
            checkOutput("resetRspId", rsp_id, 0);
            checkOutput("resetRspResult", rsp_result, 0);
`ifdef ALU_ARB_PERF_EN
            checkOutput("resetPerfOps", perf_ops, 0);
            checkOutput("resetPerfStall", perf_stall, 0);
`endif
        end else begin
`ifdef ALU_ARB_PERF_EN
            checkOutput("perfOps", perf_ops, modelOps);
            checkOutput("perfStall", perf_stall, modelStall);
`endif
            checkOutput("busy", busy, modelBusy);
            if (!modelBusy) begin
                checkOutput("rspValidIdle", rsp_valid, 0);
                monGrant = -1;
                for (int i = 1; i <= NUM_REQ; i++) begin
                    if (monGrant < 0 && req_valid[(lastGrant + i) % NUM_REQ]) begin
                        monGrant = (lastGrant + i) % NUM_REQ;
                    end
                end
                monReady = '0;
                if (monGrant >= 0) monReady[monGrant] = 1'b1;
                checkOutput("reqReadyIdle", req_ready, monReady);
                if (monGrant >= 0) begin
                    modelBusy = 1'b1;
                    expId     = monGrant;
                    expIw     = req_iw[monGrant];
                    expResult = refResult(expIw);
                    expDue    = cycle + ((expIw.opc == MUL) ? MUL_LATENCY : 1) + 2;
                    lastGrant = monGrant;
                    grantLog.push_back('{monGrant, cycle});
                end
            end else begin
                checkOutput("reqReadyBusy", req_ready, 0);
                checkOutput("aluIwHeld", alu_iw, expIw);
                if (cycle < expDue) begin
                    checkOutput("rspValidEarly", rsp_valid, 0);
                end else begin
                    checkOutput("rspValid", rsp_valid, 1);
                    checkOutput("rspId", rsp_id, expId);
                    checkOutput("rspResult", rsp_result, expResult);
                    if (rsp_ready) begin
                        modelBusy = 1'b0;
                        modelOps  = modelOps + 32'd1;
                    end else begin
                        modelStall = modelStall + 32'd1;
                    end
                end
            end
        end
    end

    task automatic doReset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic waitReady(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clock);
            if (req_ready[idx]) ok = 1'b1;
        end
        if (!ok) timeoutFail("waitReady");
    endtask

    task automatic waitRspValid(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clock);
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) timeoutFail("waitRspValid");
    endtask

    task automatic waitIdle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clock);
            if (!busy) ok = 1'b1;
        end
        if (!ok) timeoutFail("waitIdle");
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input instruction_t iw,
                                 output int lat, output logic [31:0] res, output int id);
        bit ok;
        int gc;
        lat          = -1;
        res          = '0;
        id           = -1;
        req_iw[idx]  = iw;
        req_valid    = '0;
        req_valid[idx] = 1'b1;
        rsp_ready    = 1'b1;
        waitReady(idx, 20, ok);
        gc = cycle;
        @(posedge clock);
        #1 req_valid[idx] = 1'b0;
        if (!ok) return;
        waitRspValid(50, ok);
        if (!ok) return;
        lat = cycle - gc;
        res = rsp_result;
        id  = int'(rsp_id);
        @(posedge clock);
        #1;
    endtask

    function automatic instruction_t randIw();
        instruction_t iw;
        iw.opc = opcode_t'($urandom_range(0, 5));
        iw.a   = $urandom;
        iw.b   = $urandom;
        return iw;
    endfunction

    typedef struct {
        int          idx;
        opcode_t     opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        int          expLat;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int           lat;
        int           id;
        bit           ok;
        logic [31:0]  res;
        logic [NUM_REQ-1:0] granted;

        vecs[0] = '{0, ADD, 32'd5,          32'd3,        32'd8,          3};
        vecs[1] = '{2, MUL, 32'd6,          32'd7,        32'd42,         5};
        vecs[2] = '{1, SUB, 32'd0,          32'd1,        32'hFFFF_FFFF,  3};
        vecs[3] = '{3, ADD, 32'hFFFF_FFFF,  32'd2,        32'd1,          3};
        vecs[4] = '{1, MUL, 32'h0001_0000,  32'h0001_0000, 32'd0,         5};
        vecs[5] = '{0, XOR, 32'h0000_F0F0,  32'h0000_0FF0, 32'h0000_FF00, 3};

        $display("[TB] start");
        doReset();

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].idx, '{vecs[v].opc, vecs[v].a, vecs[v].b}, lat, res, id);
            checkOutput("vecLatency", lat, vecs[v].expLat);
            checkOutput("vecResult", res, vecs[v].expRes);
            checkOutput("vecId", id, vecs[v].idx);
`ifdef ALU_ARB_PERF_EN
            if (v == 2) checkOutput("perfOpsAfter3", perf_ops, 3);
`endif
        end

        // All requesters held: expect fair rotation with back-to-back 4-cycle issue.
        doReset();
        grantLog.delete();
        for (int i = 0; i < NUM_REQ; i++) req_iw[i] = '{SUB, $urandom, $urandom};
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 100 && grantLog.size() < 5; n++) @(negedge clock);
        @(posedge clock);
        #1 req_valid = '0;
        waitIdle(50);
        checkOutput("rrCount", grantLog.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grantLog.size()) begin
                checkOutput("rrOrder", grantLog[k].idx, k % NUM_REQ);
                if (k > 0) checkOutput("rrSpacing", grantLog[k].cyc - grantLog[k-1].cyc, 4);
            end
        end

        // Backpressure in RESP while another request waits.
        doReset();
        rsp_ready = 1'b0;
        req_iw[1] = '{ADD, 32'd100, 32'd23};
        req_valid = 4'b0010;
        waitReady(1, 20, ok);
        @(posedge clock);
        #1;
        req_iw[2] = '{MUL, 32'd9, 32'd9};
        req_valid = 4'b0100;
        waitRspValid(50, ok);
        checkOutput("stallFirstResult", rsp_result, 123);
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            checkOutput("stallValid", rsp_valid, 1);
            checkOutput("stallResult", rsp_result, 123);
            checkOutput("stallId", rsp_id, 1);
            checkOutput("stallBusy", busy, 1);
            checkOutput("stallReqReady", req_ready, 0);
        end
        @(posedge clock);
        #1 rsp_ready = 1'b1;
        @(posedge clock);
        #1;
`ifdef ALU_ARB_PERF_EN
        checkOutput("perfStall4", perf_stall, 4);
`endif
        waitReady(2, 10, ok);
        checkOutput("heldReqGranted", ok, 1);
        @(posedge clock);
        #1 req_valid = '0;
        waitIdle(50);

        // Reset during a MUL drops the operation and restarts arbitration at requester 0.
        doReset();
        req_iw[2] = '{MUL, 32'd6, 32'd7};
        req_valid = 4'b0100;
        waitReady(2, 20, ok);
        @(posedge clock);
        #1 req_valid = '0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetRspValid", rsp_valid, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            checkOutput("droppedRsp", rsp_valid, 0);
        end
        @(posedge clock);
        #1;
        grantLog.delete();
        req_iw[0] = '{ADD, 32'd1, 32'd1};
        req_iw[3] = '{ADD, 32'd2, 32'd2};
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && grantLog.size() < 1; n++) @(negedge clock);
        @(posedge clock);
        #1 req_valid = '0;
        checkOutput("postResetGrantSeen", grantLog.size() >= 1, 1);
        if (grantLog.size() >= 1) checkOutput("postResetGrant", grantLog[0].idx, 0);
        waitIdle(50);

        // Random traffic: requests held until accepted, random response backpressure.
        doReset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            granted = req_valid & req_ready;
            @(posedge clock);
            #1;
            req_valid = req_valid & ~granted;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_iw[i]    = randIw();
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        waitIdle(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
